// File: rtl/ahb_button_pkg.sv
// Shared constants for the AHB button interrupt block: register offsets,
// HTRANS encodings and the latched address-phase record.
package ahb_button_pkg;

   // AHB transfer types; only NONSEQ and SEQ carry a transfer.
   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_e;

   // Register word offsets, decoded from HADDR[3:2].
   typedef enum logic [1:0] {
      REG_DATA       = 2'd0,  // 0x0 debounced levels, read-only
      REG_IRQ_EN     = 2'd1,  // 0x4 interrupt enables
      REG_IRQ_STATUS = 2'd2,  // 0x8 sticky edge status, write-1-to-clear
      REG_EDGE_SEL   = 2'd3   // 0xC per-bit edge select, 0=rising 1=falling
   } reg_sel_e;

   // Address-phase information carried into the data phase.
   typedef struct packed {
      logic     valid;
      logic     write;
      reg_sel_e sel;
   } aphase_t;

   // True for transfer types that move data.
   function automatic logic is_transfer(input logic [1:0] htrans);
      return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
   endfunction

endpackage

// File: rtl/button_debounce.sv
// One-bit button conditioner: 2-flop synchronizer, mismatch counter,
// debounced stable level and single-cycle rise/fall pulses that follow
// each change of the stable level by one cycle.
module button_debounce #(
   parameter int DB_CYCLES = 1000
) (
   input  logic HCLK,
   input  logic HRESETn,
   input  logic i_button,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   localparam int            CW       = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

   logic          r_sync1;
   logic          r_sync2;
   logic          r_level;
   logic          r_level_d;
   logic [CW-1:0] r_cnt;
   logic          w_mismatch;

   assign w_mismatch = r_sync2 ^ r_level;

   // Bring the asynchronous button level into the HCLK domain.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments let r_sync2 take the old r_sync1, forming a real two-stage chain.
         r_sync1 <= i_button;
         r_sync2 <= r_sync1;
      end
   end

   // Count consecutive mismatch cycles; accept the new level on the last one.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_level <= 1'b0;
         r_cnt   <= '0;
      end else if (w_mismatch) begin
         if (r_cnt == CNT_LAST) begin
            r_level <= r_sync2;
            r_cnt   <= '0;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end else begin
         r_cnt <= '0;
      end
   end

   // Delayed copy of the stable level for edge detection.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_level_d <= 1'b0;
      end else begin
         r_level_d <= r_level;
      end
   end

   assign o_level = r_level;
   assign o_rise  = r_level & ~r_level_d;
   assign o_fall  = ~r_level & r_level_d;

endmodule

// File: rtl/ahb_button_irq.sv
// AHB-Lite slave exposing NUM_BTN debounced buttons with per-bit edge
// selection, sticky write-1-to-clear status and a level interrupt.
module ahb_button_irq
   import ahb_button_pkg::*;
#(
   parameter int NUM_BTN   = 8,
   parameter int DB_CYCLES = 1000
) (
   input  logic               HCLK,
   input  logic               HRESETn,
   input  logic               HSEL,
   input  logic               HREADY,
   input  logic [31:0]        HADDR,
   input  logic [1:0]         HTRANS,
   input  logic               HWRITE,
   input  logic [2:0]         HSIZE,
   input  logic [31:0]        HWDATA,
   input  logic [NUM_BTN-1:0] BUTTON,
   output logic               HREADYOUT,
   output logic [31:0]        HRDATA,
   output logic               IRQ
);

   aphase_t              r_aphase;
   logic [NUM_BTN-1:0]   r_irq_en;
   logic [NUM_BTN-1:0]   r_irq_status;
   logic [NUM_BTN-1:0]   r_edge_sel;
   logic                 r_irq;

   logic [NUM_BTN-1:0]   w_level;
   logic [NUM_BTN-1:0]   w_rise;
   logic [NUM_BTN-1:0]   w_fall;
   logic [NUM_BTN-1:0]   w_set;
   logic [NUM_BTN-1:0]   w_w1c;
   logic [NUM_BTN-1:0]   w_wdata;
   logic [NUM_BTN-1:0]   w_rdata;
   logic                 w_accept;
   logic                 w_wr_en;
   logic                 w_rd_en;
   logic                 w_unused;

   // One conditioner per button input.
   for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
      button_debounce #(
         .DB_CYCLES (DB_CYCLES)
      ) u_debounce (
         .HCLK     (HCLK),
         .HRESETn  (HRESETn),
         .i_button (BUTTON[g]),
         .o_level  (w_level[g]),
         .o_rise   (w_rise[g]),
         .o_fall   (w_fall[g])
      );
   end

   // Bus bits that carry no information for this slave.
   if (NUM_BTN < 32) begin : g_pad
      assign w_unused = ^{HSIZE, HADDR[31:4], HADDR[1:0], HWDATA[31:NUM_BTN]};
   end else begin : g_nopad
      assign w_unused = ^{HSIZE, HADDR[31:4], HADDR[1:0]};
   end

   assign w_accept = HSEL & HREADY & is_transfer(HTRANS);
   assign w_wr_en  = r_aphase.valid & r_aphase.write;
   assign w_rd_en  = r_aphase.valid & ~r_aphase.write;
   assign w_wdata  = HWDATA[NUM_BTN-1:0];

   // An edge event fires when the stable-level transition matches EDGE_SEL.
   assign w_set = (w_rise & ~r_edge_sel) | (w_fall & r_edge_sel);
   assign w_w1c = (w_wr_en && (r_aphase.sel == REG_IRQ_STATUS)) ? w_wdata : '0;

   // Capture the address phase; the valid flag drops when no transfer is accepted.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_aphase <= '0;
      end else if (w_accept) begin
         r_aphase <= '{valid: 1'b1, write: HWRITE, sel: reg_sel_e'(HADDR[3:2])};
      end else begin
         r_aphase.valid <= 1'b0;
      end
   end

   // Plain read/write control registers, updated at the end of the data phase.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_irq_en   <= '0;
         r_edge_sel <= '0;
      end else if (w_wr_en) begin
         case (r_aphase.sel)
            REG_IRQ_EN:   r_irq_en   <= w_wdata;
            REG_EDGE_SEL: r_edge_sel <= w_wdata;
            default:      ;
         endcase
      end
   end

   // Sticky status: clear is applied first so a same-cycle event survives.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_irq_status <= '0;
      end else begin
         r_irq_status <= (r_irq_status & ~w_w1c) | w_set;
      end
   end

   // Registered interrupt output.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_irq <= 1'b0;
      end else begin
         r_irq <= |(r_irq_status & r_irq_en);
      end
   end

   // Data-phase read mux driven from the latched offset.
   always_comb begin
      // NOTE: default first so every path assigns w_rdata and no latch is inferred.
      w_rdata = '0;
      if (w_rd_en) begin
         case (r_aphase.sel)
            REG_DATA:       w_rdata = w_level;
            REG_IRQ_EN:     w_rdata = r_irq_en;
            REG_IRQ_STATUS: w_rdata = r_irq_status;
            REG_EDGE_SEL:   w_rdata = r_edge_sel;
            default:        w_rdata = '0;
         endcase
      end
   end

   assign HRDATA    = 32'(w_rdata);
   assign HREADYOUT = 1'b1;
   assign IRQ       = r_irq;

endmodule

// File: tb/tb_ahb_button_irq.sv
// Self-checking bench for ahb_button_irq (NUM_BTN=5, DB_CYCLES=4): directed
// steps followed by random bus/button traffic against a behavioural model.
module tb_ahb_button_irq;
   import ahb_button_pkg::*;

   localparam int NB = 5;
   localparam int DB = 4;

   logic          HCLK = 1'b0;
   logic          HRESETn;
   logic          HSEL;
   logic          HREADY;
   logic [31:0]   HADDR;
   logic [1:0]    HTRANS;
   logic          HWRITE;
   logic [2:0]    HSIZE;
   logic [31:0]   HWDATA;
   logic [NB-1:0] btn;
   logic          HREADYOUT;
   logic [31:0]   HRDATA;
   logic          IRQ;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   // Behavioural model state: raw input history plus register images.
   logic [NB-1:0] hist[$];
   logic [NB-1:0] m_data, m_prev, m_en, m_st, m_es;
   logic          m_irq, m_v, m_w;
   logic [1:0]    m_off;

   always #5 HCLK = ~HCLK;

   ahb_button_irq #(
      .NUM_BTN   (NB),
      .DB_CYCLES (DB)
   ) dut (
      .HCLK      (HCLK),
      .HRESETn   (HRESETn),
      .HSEL      (HSEL),
      .HREADY    (HREADY),
      .HADDR     (HADDR),
      .HTRANS    (HTRANS),
      .HWRITE    (HWRITE),
      .HSIZE     (HSIZE),
      .HWDATA    (HWDATA),
      .BUTTON    (btn),
      .HREADYOUT (HREADYOUT),
      .HRDATA    (HRDATA),
      .IRQ       (IRQ)
   );

   task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
      n_checks++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_reg(input logic [1:0] off);
      case (off)
         2'd0:    return 32'(m_data);
         2'd1:    return 32'(m_en);
         2'd2:    return 32'(m_st);
         default: return 32'(m_es);
      endcase
   endfunction

   function automatic logic [31:0] model_hrdata();
      return (m_v && !m_w) ? model_reg(m_off) : 32'h0;
   endfunction

   // History is seeded with the reset value of the synchronized input.
   task automatic model_reset();
      hist.delete();
      for (int i = 0; i < DB + 2; i++) hist.push_back('0);
      m_data = '0; m_prev = '0; m_en = '0; m_st = '0; m_es = '0;
      m_irq = 1'b0; m_v = 1'b0; m_w = 1'b0; m_off = 2'd0;
   endtask

   // A level is accepted once the DB samples that are at least two edges old
   // all disagree with the current debounced level.
   task automatic model_step();
      logic [NB-1:0] nd, set, w1c, wd;
      logic          wr;
      hist.push_back(btn);
      if (hist.size() > DB + 2) void'(hist.pop_front());
      nd = m_data;
      for (int b = 0; b < NB; b++) begin
         logic held;
         held = 1'b1;
         for (int j = 0; j < DB; j++) if (hist[j][b] == m_data[b]) held = 1'b0;
         if (held) nd[b] = ~m_data[b];
      end
      wd    = HWDATA[NB-1:0];
      wr    = m_v & m_w;
      set   = (m_data & ~m_prev & ~m_es) | (~m_data & m_prev & m_es);
      w1c   = (wr && m_off == 2'd2) ? wd : '0;
      m_irq = |(m_st & m_en);
      m_st  = (m_st & ~w1c) | set;
      if (wr && m_off == 2'd1) m_en = wd;
      if (wr && m_off == 2'd3) m_es = wd;
      m_prev = m_data;
      m_data = nd;
      m_v    = HSEL & HREADY & HTRANS[1];
      m_off  = HADDR[3:2];
      m_w    = HWRITE;
   endtask

   // Advance one clock, update the model, then compare outputs 1 time unit later.
   task automatic tick();
      @(posedge HCLK);
      if (!HRESETn) model_reset();
      else          model_step();
      #1;
      check(HREADYOUT, 32'h1, "hreadyout");
      check(HRDATA, model_hrdata(), "hrdata_vs_model");
      check(IRQ, m_irq, "irq_vs_model");
   endtask

   task automatic idle();
      HSEL   = 1'b0;
      HTRANS = HTRANS_IDLE;
      HWRITE = 1'b0;
      HADDR  = 32'h0;
   endtask

   task automatic addr(input logic [1:0] off, input logic write);
      HSEL   = 1'b1;
      HTRANS = HTRANS_NONSEQ;
      HWRITE = write;
      HADDR  = {28'h0, off, 2'b00};
   endtask

   task automatic rd(input logic [1:0] off, input logic [31:0] exp, input string tag);
      addr(off, 1'b0);
      tick();
      check(HRDATA, exp, tag);
      idle();
   endtask

   task automatic wr(input logic [1:0] off, input logic [31:0] data);
      addr(off, 1'b1);
      tick();
      idle();
      HWDATA = data;
      tick();
   endtask

   // Write data phase overlapped with a read address phase to the same register.
   task automatic wr_rd(input logic [1:0] off, input logic [31:0] data,
                        input logic [31:0] exp, input string tag);
      addr(off, 1'b1);
      tick();
      HWDATA = data;
      addr(off, 1'b0);
      tick();
      check(HRDATA, exp, tag);
      idle();
   endtask

   initial begin
      HRESETn = 1'b0;
      btn     = '0;
      HREADY  = 1'b1;
      HWDATA  = 32'h0;
      HSIZE   = 3'b010;
      idle();
      model_reset();
      repeat (3) tick();
      check(IRQ, 32'h0, "irq_in_reset");
      check(HRDATA, 32'h0, "hrdata_in_reset");
      HRESETn = 1'b1;

      // Register reset values.
      rd(REG_DATA,       32'h0, "reset_data");
      rd(REG_IRQ_EN,     32'h0, "reset_irq_en");
      rd(REG_IRQ_STATUS, 32'h0, "reset_irq_status");
      rd(REG_EDGE_SEL,   32'h0, "reset_edge_sel");

      // Glitch of DB-1 cycles is rejected.
      btn[0] = 1'b1;
      repeat (DB - 1) tick();
      btn[0] = 1'b0;
      repeat (10) tick();
      rd(REG_DATA,       32'h0, "glitch_data");
      rd(REG_IRQ_STATUS, 32'h0, "glitch_status");

      // Clean press on bit 3: DATA after DB+2 cycles, status one later, IRQ one after that.
      wr(REG_IRQ_EN, 32'h08);
      addr(REG_DATA, 1'b0);
      btn[3] = 1'b1;
      repeat (DB + 1) tick();
      check(HRDATA, 32'h0, "data_before_accept");
      tick();
      check(HRDATA, 32'h08, "data_at_db_plus_2");
      addr(REG_IRQ_STATUS, 1'b0);
      tick();
      check(HRDATA, 32'h08, "status_after_rise");
      check(IRQ, 32'h0, "irq_not_yet");
      tick();
      check(IRQ, 32'h1, "irq_one_after_status");
      idle();
      wr(REG_IRQ_STATUS, 32'h08);
      btn[3] = 1'b0;
      repeat (10) tick();
      rd(REG_IRQ_STATUS, 32'h0, "status_after_w1c_and_fall");
      check(IRQ, 32'h0, "irq_dropped");

      // Falling-edge select on bit 0.
      wr(REG_EDGE_SEL, 32'h01);
      wr(REG_IRQ_EN, 32'h01);
      btn[0] = 1'b1;
      repeat (10) tick();
      rd(REG_IRQ_STATUS, 32'h0, "no_status_on_rise_when_fall_sel");
      btn[0] = 1'b0;
      repeat (10) tick();
      rd(REG_IRQ_STATUS, 32'h01, "status_on_fall");
      check(IRQ, 32'h1, "irq_on_fall");
      wr(REG_IRQ_STATUS, 32'h01);
      repeat (2) tick();
      rd(REG_IRQ_STATUS, 32'h0, "status_cleared_w1c");
      check(IRQ, 32'h0, "irq_cleared_w1c");

      // Set event and W1C land on the same edge: the set wins.
      btn[1] = 1'b1;
      repeat (DB + 1) tick();
      wr(REG_IRQ_STATUS, 32'h02);
      rd(REG_IRQ_STATUS, 32'h02, "set_beats_w1c");

      // Register width masking and read-only DATA.
      wr(REG_IRQ_EN, 32'hFFFF_FFFF);
      rd(REG_IRQ_EN, 32'h0000_001F, "irq_en_width_mask");
      rd(REG_DATA, 32'h02, "data_before_write");
      wr(REG_DATA, 32'hFFFF_FFFF);
      rd(REG_DATA, 32'h02, "data_write_ignored");
      wr(REG_IRQ_STATUS, 32'hFFFF_FFFF);

      // Back-to-back write then read with no stall.
      wr_rd(REG_EDGE_SEL, 32'h15, 32'h15, "b2b_edge_sel");
      wr_rd(REG_IRQ_EN, 32'hABCD_0012, 32'h12, "b2b_irq_en");

      // Reset in mid-debounce of bit 2 while bit 1 stays held high.
      btn[2] = 1'b1;
      repeat (3) tick();
      HRESETn = 1'b0;
      model_reset();
      #1;
      check(IRQ, 32'h0, "irq_async_reset");
      repeat (2) tick();
      btn[2]  = 1'b0;
      HRESETn = 1'b1;
      addr(REG_DATA, 1'b0);
      repeat (DB + 1) tick();
      check(HRDATA, 32'h0, "held_button_before_accept");
      tick();
      check(HRDATA, 32'h02, "held_button_after_reset");
      addr(REG_IRQ_STATUS, 1'b0);
      tick();
      check(HRDATA, 32'h02, "rise_event_after_reset");
      idle();

      // Random bus and button traffic against the model.
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 4) == 0) btn = NB'($urandom);
         HSEL   = ($urandom_range(0, 3) != 0);
         HREADY = ($urandom_range(0, 7) != 0);
         HTRANS = 2'($urandom);
         HWRITE = 1'($urandom);
         HADDR  = $urandom;
         HWDATA = $urandom;
         tick();
      end
      idle();
      HREADY = 1'b1;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/ahb_button_irq.md
AHB_BUTTON_IRQ -- requirements
Module: ahb_button_irq

Interface
REQ-001 Parameter NUM_BTN, default 8: number of button inputs, legal range 1..32.
REQ-002 Parameter DB_CYCLES, default 1000: consecutive HCLK cycles an input must hold a new level before it is accepted, minimum 2.
REQ-003 HCLK  in  1  clock; all state on rising edge.
REQ-004 HRESETn  in  1  reset, asynchronous, active-low.
REQ-005 HSEL  in  1  slave select.
REQ-006 HREADY  in  1  bus ready; an address phase is accepted only when high.
REQ-007 HADDR  in  32  address; only HADDR[3:2] decoded.
REQ-008 HTRANS  in  2  transfer type; NONSEQ/SEQ (HTRANS[1]=1) are valid.
REQ-009 HWRITE  in  1  1=write.
REQ-010 HSIZE  in  3  ignored; all accesses treated as word.
REQ-011 HWDATA  in  32  write data, sampled in the data phase.
REQ-012 BUTTON  in  NUM_BTN  raw asynchronous button levels.
REQ-013 HREADYOUT  out  1  constant 1 (zero wait states).
REQ-014 HRDATA  out  32  read data; bits above NUM_BTN read 0.
REQ-015 IRQ  out  1  level interrupt, high while any enabled status bit is set.

Function
REQ-016 Address phase latched (sel, addr[3:2], write) when HSEL & HREADY & HTRANS[1]; otherwise the latched valid flag clears.
REQ-017 Register map, word offsets: 0x0 DATA (RO, debounced levels), 0x4 IRQ_EN (RW), 0x8 IRQ_STATUS (RW1C), 0xC EDGE_SEL (RW, per bit 0=rising, 1=falling).
REQ-018 Write takes effect at the end of the data-phase cycle; writes to DATA are ignored.
REQ-019 HRDATA is driven combinationally in the data phase from the latched offset; it is 0 when no valid read is latched.
REQ-020 Each BUTTON bit passes a 2-flop synchronizer before any other logic.
REQ-021 Per bit: while the synchronized level differs from the stable level, the counter increments; when it equals the stable level, the counter clears.
REQ-022 When the counter reaches DB_CYCLES-1 with a mismatch, the stable level takes the synchronized value on that edge and the counter clears.
REQ-023 A glitch shorter than DB_CYCLES synchronized cycles never changes the stable level.
REQ-024 Total latency from a clean BUTTON change to a DATA update is DB_CYCLES+2 cycles.
REQ-025 A stable-level transition matching EDGE_SEL sets its IRQ_STATUS bit on the next edge, regardless of IRQ_EN.
REQ-026 If a set event and a W1C of the same bit occur in the same cycle, the set wins.
REQ-027 IRQ = |(IRQ_STATUS & IRQ_EN), registered once, so it rises 1 cycle after the status bit.
REQ-028 Back-to-back transfers are supported: a write data phase and the next address phase overlap with no stall.

Reset
REQ-029 On HRESETn low: synchronizers, stable levels, counters, IRQ_EN, IRQ_STATUS, EDGE_SEL, latched address phase and IRQ all clear to 0.
REQ-030 After reset release, buttons already held high are accepted after DB_CYCLES+2 cycles and generate a rising-edge event.
REQ-031 Reset asserted mid-debounce discards the partial count; no event is produced.

Structure
REQ-032 Package ahb_button_pkg holds the register offset constants (DATA/IRQ_EN/IRQ_STATUS/EDGE_SEL) and HTRANS encodings.
REQ-033 Sub-module button_debounce (one bit: synchronizer, counter, stable level, rise/fall pulses) is instantiated NUM_BTN times via generate.

Verification
REQ-034 Reset, then read 0x0/0x4/0x8/0xC -> all 0x00000000; HREADYOUT=1 throughout.
REQ-035 DB_CYCLES=4: BUTTON[0] high for 3 cycles then low -> DATA stays 0x0, no status bit set.
REQ-036 DB_CYCLES=4: BUTTON[3] held high -> DATA=0x08 exactly 6 cycles later; IRQ_STATUS=0x08; with IRQ_EN=0x08, IRQ high 1 cycle after the status bit.
REQ-037 EDGE_SEL=0x01; BUTTON[0] rises then falls, both held -> status set only after the fall; a W1C of 0x01 clears it and IRQ drops.
REQ-038 W1C to IRQ_STATUS in the same cycle a new edge event sets that bit -> the bit reads 1 afterwards.
REQ-039 NUM_BTN=5: write 0xFFFFFFFF to IRQ_EN, read back -> 0x0000001F; write to 0x0 -> DATA unchanged.
